// File: rtl/soc_mem_stream_loader.sv
// Stream-to-memory loader: packs an 8-bit packet stream (sop/eop framed)
// into little-endian 32-bit words and writes them to consecutive word
// addresses starting at cfg_base. Overruns past the top of memory are
// flagged and the rest of the packet is drained without writing.
module soc_mem_stream_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              cfg_start,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_startofpacket,
  input  logic              in_endofpacket,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOP,
    FILL,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;        // word address of the word being packed
  logic [1:0]        lane;       // next byte lane to fill
  logic [3:0]        lane_en;    // lanes filled so far in the current word
  logic [31:0]       word;       // packed word, unfilled lanes held at zero
  logic              last_eop;   // most recently packed byte ended the packet
  logic              discard;    // memory end passed: drain rest of packet

  assign mem_clken = 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked register is updated with <= so all flops sample
    // the same pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and all handshake / memory-port outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    in_ready       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    case (state)
      IDLE: begin
        if (cfg_start) state_nxt = WAIT_SOP;
      end
      WAIT_SOP: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && in_startofpacket)
          state_nxt = in_endofpacket ? WRITE : FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (discard) begin
            if (in_endofpacket) state_nxt = DONE;
          end else if (lane == 2'd3 || in_endofpacket) begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = ptr;
        mem_writedata  = word;
        mem_byteenable = lane_en;
        state_nxt      = last_eop ? DONE : FILL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address pointer, byte packing, counters and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      word_count <= '0;
      lane       <= '0;
      lane_en    <= '0;
      word       <= '0;
      last_eop   <= 1'b0;
      overflow   <= 1'b0;
      discard    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            ptr        <= cfg_base;
            word_count <= '0;
            lane       <= '0;
            lane_en    <= '0;
            word       <= '0;
            last_eop   <= 1'b0;
            overflow   <= 1'b0;
            discard    <= 1'b0;
          end
        end
        WAIT_SOP: begin
          // Non-sop bytes are accepted and dropped; sop byte lands in lane 0.
          if (in_valid && in_startofpacket) begin
            word     <= {24'h0, in_data};
            lane_en  <= 4'b0001;
            lane     <= 2'd1;
            last_eop <= in_endofpacket;
          end
        end
        FILL: begin
          // A sop seen here is just data; the packet is already open.
          if (in_valid && !discard) begin
            word[{lane, 3'b000} +: 8] <= in_data;
            lane_en[lane]             <= 1'b1;
            lane                      <= lane + 2'd1;
            last_eop                  <= in_endofpacket;
          end
        end
        WRITE: begin
          word_count <= word_count + 1'b1;
          lane       <= '0;
          lane_en    <= '0;
          word       <= '0;
          ptr        <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
          // Top word written with more packet to come: stop writing.
          if (!last_eop && ptr == LAST_ADDR) begin
            overflow <= 1'b1;
            discard  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_mem_stream_loader.sv
// Self-checking bench for soc_mem_stream_loader: directed scenarios plus
// randomized packets compared against a packet-level reference model.
module tb_soc_mem_stream_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cfg_base;
  logic              cfg_start;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_startofpacket;
  logic              in_endofpacket;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;

  soc_mem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cfg_base(cfg_base), .cfg_start(cfg_start),
    .busy(busy), .done(done), .overflow(overflow), .word_count(word_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
    int                c;
  } wr_t;

  wr_t         obs[$];
  wr_t         exp_q[$];
  logic [7:0]  pd[$];
  bit          ps[$];
  bit          pe[$];
  int          acc_cyc[$];
  bit          exp_ovf;
  int          exp_cnt;

  // Write monitor: record every strobe and sanity-check the port around it.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      obs.push_back('{mem_address, mem_writedata, mem_byteenable, cyc});
      checks++;
      if (mem_chipselect !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_strobe cs=%b busy=%b in_ready=%b, required cs=1 busy=1 in_ready=0",
                 mem_chipselect, busy, in_ready);
      end
    end
  end

  // Reference model: first sop opens the packet, bytes pack little-endian
  // into words at base, base+1, ...; eop flushes a partial word; a packet
  // that continues after the word at DEPTH-1 sets overflow and writes no more.
  task automatic build_model(input logic [ADDR_W-1:0] base);
    bit          started = 0;
    bit          full    = 0;
    int          lane    = 0;
    logic [31:0] w       = '0;
    logic [3:0]  be      = '0;
    int          addr    = int'(base);
    logic [ADDR_W-1:0] a;
    exp_q.delete();
    exp_ovf = 0;
    exp_cnt = 0;
    for (int i = 0; i < pd.size(); i++) begin
      if (!started && !ps[i]) continue;
      started = 1;
      if (full) begin
        if (pe[i]) break;
        continue;
      end
      w = w | (32'(pd[i]) << (8 * lane));
      be[lane] = 1'b1;
      lane++;
      if (lane == 4 || pe[i]) begin
        a = addr[ADDR_W-1:0];
        exp_q.push_back('{a, w, be, 0});
        exp_cnt++;
        if (pe[i]) break;
        if (addr == DEPTH - 1) begin
          full    = 1;
          exp_ovf = 1;
        end else begin
          addr++;
        end
        lane = 0;
        w    = '0;
        be   = '0;
      end
    end
  endtask

  // Build the stimulus stream: junk bytes without sop, then one packet.
  task automatic make_packet(input int junk, input int len, input bit seq,
                             input logic [7:0] first, input bit mid_sop);
    pd.delete(); ps.delete(); pe.delete();
    for (int i = 0; i < junk; i++) begin
      pd.push_back(8'($urandom));
      ps.push_back(1'b0);
      pe.push_back(1'($urandom));
    end
    for (int i = 0; i < len; i++) begin
      pd.push_back(seq ? first + 8'(i) : 8'($urandom));
      ps.push_back(i == 0 || (mid_sop && ($urandom_range(0, 3) == 0)));
      pe.push_back(i == len - 1);
    end
  endtask

  // Present one byte and hold it until the DUT accepts it (bounded).
  task automatic send_byte(input logic [7:0] d, input bit s, input bit e, input int gap);
    bit ok = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_data          = d;
    in_startofpacket = s;
    in_endofpacket   = e;
    in_valid         = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    in_valid         = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout byte=%h not accepted in 64 cycles, required acceptance", d);
    end
  endtask

  task automatic send_stream(input bit gaps, input int mid_start_idx);
    for (int i = 0; i < pd.size(); i++) begin
      if (i == mid_start_idx) begin
        cfg_base  = ADDR_W'($urandom);
        cfg_start = 1'b1;
      end
      send_byte(pd[i], ps[i], pe[i], gaps ? int'($urandom_range(0, 2)) : 0);
      cfg_start = 1'b0;
    end
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] base);
    cfg_base  = base;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_base  = ADDR_W'($urandom);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || overflow !== 1'b0 || word_count !== '0) begin
      errors++;
      $display("FAIL start_state busy=%b overflow=%b word_count=%0d, required busy=1 overflow=0 word_count=0",
               busy, overflow, word_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int t = 0; t < 64 && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout done never pulsed in 64 cycles, required a done pulse");
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL done_busy busy=%b during done, required 0", busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_width done=%b one cycle after pulse, required 0", done);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic compare_result(input string name);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_write_count got %0d writes, required %0d", name, obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].be !== exp_q[i].be) begin
        errors++;
        $display("FAIL %s_write%0d got addr=%h data=%h be=%h, required addr=%h data=%h be=%h",
                 name, i, obs[i].addr, obs[i].data, obs[i].be,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].be);
      end
    end
    checks++;
    if (word_count !== (ADDR_W+1)'(exp_cnt) || overflow !== exp_ovf || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status word_count=%0d overflow=%b busy=%b, required word_count=%0d overflow=%b busy=0",
               name, word_count, overflow, busy, exp_cnt, exp_ovf);
    end
  endtask

  task automatic run_transfer(input string name, input logic [ADDR_W-1:0] base,
                              input bit gaps, input int mid_start_idx);
    obs.delete();
    acc_cyc.delete();
    build_model(base);
    start_xfer(base);
    send_stream(gaps, mid_start_idx);
    wait_done();
    compare_result(name);
  endtask

  task automatic expect_reset_outputs(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || word_count !== '0 ||
        in_ready !== 1'b0 || mem_chipselect !== 1'b0 || mem_write !== 1'b0 ||
        mem_byteenable !== 4'h0 || mem_address !== '0 || mem_writedata !== 32'h0 ||
        mem_clken !== 1'b1) begin
      errors++;
      $display("FAIL %s busy=%b done=%b ovf=%b wc=%0d rdy=%b cs=%b wr=%b be=%h addr=%h wd=%h clken=%b, required all 0 and clken=1",
               name, busy, done, overflow, word_count, in_ready, mem_chipselect, mem_write,
               mem_byteenable, mem_address, mem_writedata, mem_clken);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_reset_outputs("reset_values");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    make_packet(0, 8, 1, 8'h01, 0);
    run_transfer("base010", 10'h010, 0, -1);
    checks++;
    if (obs.size() != 2 || obs[0].data !== 32'h04030201 || obs[1].data !== 32'h08070605 ||
        obs[1].addr !== 10'h011) begin
      errors++;
      $display("FAIL base010_const got %0d writes, required 0x04030201@010 and 0x08070605@011", obs.size());
    end

    make_packet(0, 6, 1, 8'hA0, 0);
    run_transfer("base020", 10'h020, 1, -1);
    checks++;
    if (obs.size() != 2 || obs[1].data !== 32'h0000A5A4 || obs[1].be !== 4'h3) begin
      errors++;
      $display("FAIL base020_tail got %0d writes, required second write 0x0000A5A4 be=3", obs.size());
    end

    make_packet(0, 9, 1, 8'h50, 0);
    run_transfer("overflow", 10'h3FF, 0, -1);
    checks++;
    if (acc_cyc.size() != 9 || overflow !== 1'b1 || word_count !== 11'd1) begin
      errors++;
      $display("FAIL overflow_const accepted=%0d overflow=%b word_count=%0d, required 9 1 1",
               acc_cyc.size(), overflow, word_count);
    end

    make_packet(3, 4, 1, 8'h11, 0);
    run_transfer("leading_junk", 10'h000, 0, -1);
    checks++;
    if (obs.size() != 1 || obs[0].data !== 32'h14131211 || obs[0].addr !== 10'h000) begin
      errors++;
      $display("FAIL leading_junk_const got %0d writes, required single 0x14131211@000", obs.size());
    end
  endtask

  task automatic test_throughput();
    make_packet(0, 8, 1, 8'h30, 0);
    run_transfer("throughput", 10'h100, 0, -1);
    checks++;
    if (obs.size() < 2 || acc_cyc.size() < 4) begin
      errors++;
      $display("FAIL throughput_data writes=%0d accepts=%0d, required >=2 and >=4", obs.size(), acc_cyc.size());
    end else if (obs[0].c != acc_cyc[3] + 1 || obs[1].c - obs[0].c != 5 || acc_cyc[3] - acc_cyc[0] != 3) begin
      errors++;
      $display("FAIL throughput first_wr=%0d acc4=%0d spacing=%0d burst=%0d, required acc4+1, 5, 3",
               obs[0].c, acc_cyc[3], obs[1].c - obs[0].c, acc_cyc[3] - acc_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    make_packet(0, 8, 1, 8'h70, 0);
    obs.delete();
    start_xfer(10'h040);
    send_byte(pd[0], ps[0], pe[0], 0);
    send_byte(pd[1], ps[1], pe[1], 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expect_reset_outputs("reset_mid_values");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    expect_reset_outputs("reset_mid_release");
    repeat (4) @(negedge clk);
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_writes got %0d writes, required 0", obs.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    make_packet(1, 10, 1, 8'hC0, 0);
    run_transfer("start_ignored", 10'h080, 0, 3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [ADDR_W-1:0] base;
      if ($urandom_range(0, 3) == 0) base = ADDR_W'(DEPTH - 1 - int'($urandom_range(0, 3)));
      else                           base = ADDR_W'($urandom_range(0, DEPTH - 1));
      make_packet($urandom_range(0, 3), $urandom_range(1, 20), 0, 8'h00, 1'($urandom));
      run_transfer("random", base, 1'($urandom), -1);
    end
  endtask

  initial begin
    reset            = 1'b1;
    cfg_base         = '0;
    cfg_start        = 1'b0;
    in_data          = '0;
    in_valid         = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    test_reset();
    test_directed();
    test_throughput();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_mem_stream_loader.md
SOC_MEM_STREAM_LOADER -- requirements
Module: soc_mem_stream_loader

Interface
REQ-001 Parameters SHALL be: ADDR_W, 10, word-address width of the target memory; DEPTH, 1024, number of 32-bit words in the target memory.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high (ports clk and reset).
REQ-003 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  clock, all logic on the rising edge
 reset  in  1  synchronous active-high reset
 cfg_base  in  ADDR_W  first word address, sampled on cfg_start
 cfg_start  in  1  one-cycle start pulse
 busy  out  1  high from accepted start until done
 done  out  1  one-cycle completion pulse
 overflow  out  1  sticky: packet exceeded the memory end; cleared on next accepted start
 word_count  out  ADDR_W+1  words written in the current or last transfer
 in_data  in  8  stream byte
 in_valid  in  1  stream byte valid
 in_ready  out  1  stream byte accepted when in_valid & in_ready
 in_startofpacket  in  1  first byte of packet
 in_endofpacket  in  1  last byte of packet
 mem_address  out  ADDR_W  memory word address
 mem_byteenable  out  4  byte lanes written
 mem_chipselect  out  1  memory select
 mem_write  out  1  write strobe
 mem_writedata  out  32  packed write word
 mem_clken  out  1  memory clock enable, constant 1

Function
REQ-004 The FSM SHALL have states IDLE, WAIT_SOP, FILL, WRITE, DONE.
REQ-005 IDLE: in_ready=0; cfg_start=1 SHALL latch cfg_base into the address pointer, clear word_count, lane index and overflow, and enter WAIT_SOP next cycle.
REQ-006 cfg_start SHALL be ignored in every state other than IDLE.
REQ-007 WAIT_SOP: in_ready=1; bytes without in_startofpacket SHALL be consumed and discarded; a byte with in_startofpacket SHALL be stored in lane 0 and the state moves to FILL (or WRITE if it also carries in_endofpacket).
REQ-008 FILL: in_ready=1; the accepted byte SHALL be stored in lane = lane index (byte k of the word at bits 8k+7:8k, little-endian), setting the corresponding enable bit.
REQ-009 After an accept that fills lane 3 or carries in_endofpacket, the state SHALL be WRITE in the next cycle.
REQ-010 WRITE: in_ready=0; for exactly one cycle mem_chipselect=1, mem_write=1, mem_address=pointer, mem_writedata=packed word, mem_byteenable=accumulated lane enables (unfilled lanes 0, data in those lanes 0).
REQ-011 On leaving WRITE the pointer SHALL increment, word_count SHALL increment, and the lane enables/index SHALL clear; next state is DONE if the last packed byte carried in_endofpacket, else FILL.
REQ-012 in_startofpacket seen in FILL SHALL be treated as ordinary data.
REQ-013 Overflow: if the pointer wraps past DEPTH-1 (a write was issued at address DEPTH-1 and more bytes follow), overflow SHALL set, no further mem_write SHALL be issued, and remaining bytes SHALL be consumed (in_ready=1) and discarded until in_endofpacket, then DONE.
REQ-014 DONE: done=1 for exactly one cycle, busy=0 in that cycle, next state IDLE.
REQ-015 busy SHALL be 1 in WAIT_SOP, FILL, WRITE; 0 in IDLE and DONE.
REQ-016 Throughput SHALL be 4 bytes per 5 cycles with in_valid held high; the first write strobe occurs the cycle after the 4th byte is accepted.
REQ-017 mem_chipselect/mem_write SHALL be 0 in all states except WRITE.

Reset
REQ-018 While reset=1 at a rising edge: state IDLE, busy=0, done=0, overflow=0, word_count=0, in_ready=0, mem_chipselect=0, mem_write=0, mem_byteenable=0, mem_address=0, mem_writedata=0; mem_clken=1.
REQ-019 Reset mid-transfer SHALL discard the partial word; no memory write SHALL occur in the cycle after reset deasserts.

Verification
REQ-020 cfg_base=0x010, packet 8 bytes 0x01..0x08 -> writes 0x04030201 @0x010 be=0xF, 0x08070605 @0x011 be=0xF; done pulse; word_count=2.
REQ-021 cfg_base=0x020, packet 6 bytes 0xA0..0xA5 -> 0xA3A2A1A0 @0x020 be=0xF, 0x0000A5A4 @0x021 be=0x3; word_count=2.
REQ-022 cfg_base=0x3FF, 9-byte packet -> one write @0x3FF be=0xF, overflow=1, no further writes, all 9 bytes consumed, done pulse, word_count=1.
REQ-023 Three bytes without sop then 4-byte packet 0x11..0x14 (cfg_base=0) -> leading bytes dropped; single write 0x14131211 @0x000.
REQ-024 Reset asserted after 2 bytes of a packet, cfg_start pulsed during busy in another run -> no write after reset, all outputs at reset values; mid-run start ignored, transfer completes unchanged.
